// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl: rate-change sequencer for a variable-ratio 5-stage CIC decimator.
// It debounces the host rate code and maps it to a decimation ratio. A rate change
// drains the current output sample, clears the CIC, and mutes the settling outputs.
// After that, the controller returns to transparent forwarding of CIC output samples.
module cic_rate_ctrl #(
  parameter int DATA_WIDTH     = 18,
  parameter int STABLE_CYCLES  = 4,
  parameter int CLEAR_CYCLES   = 8,
  parameter int SETTLE_OUTPUTS = 5,
  parameter int DRAIN_TIMEOUT  = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            rate_code,
  input  logic                  adc_strobe,
  output logic                  cic_in_strobe,
  output logic [5:0]            decimation,
  output logic                  cic_clear,
  input  logic                  cic_out_strobe,
  input  logic [DATA_WIDTH-1:0] cic_out_data,
  output logic                  out_strobe,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  // Sequencer states
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_CLEAR  = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  // Rate code 3 is reserved and must never reach the CIC
  localparam logic [1:0] CODE_RSVD = 2'd3;

  // The debounce counter saturates at STABLE_CYCLES-1. The code is accepted on the
  // clock that brings it there, which is the STABLE_CYCLES-th consecutive sample.
  localparam logic [3:0] STABLE_MAX  = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 2);
  localparam logic [7:0] CLEAR_LAST  = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [3:0] SETTLE_N    = 4'(SETTLE_OUTPUTS);

  // Map a host rate code to the CIC decimation ratio.
  // 48k -> 20, 96k -> 10, 192k -> 5; the reserved code falls back to 48k.
  function automatic logic [5:0] ratio_of(input logic [1:0] code);
    case (code)
      2'd1:    ratio_of = 6'd10;
      2'd2:    ratio_of = 6'd5;
      default: ratio_of = 6'd20;
    endcase
  endfunction

  logic [1:0] state;
  logic [1:0] state_next;
  logic       enter_clear;
  logic       code_changed;
  logic       forward;

  logic [1:0] cand;
  logic [3:0] dcount;
  logic [1:0] stable_code;
  logic [1:0] cur_code;

  logic [7:0] cnt;
  logic [7:0] timer;
  logic [3:0] scnt;
  logic [3:0] scnt_inc;

  // Debounce: a candidate code must be sampled on STABLE_CYCLES consecutive clocks
  // before it is accepted; the reserved code is tracked but never accepted.
  always_ff @(posedge clock) begin
    // NOTE: every clocked register uses non-blocking assignment so that all flops
    // sample pre-edge values; blocking here would create order-dependent races.
    if (!reset_n) begin
      cand        <= 2'd0;
      dcount      <= 4'd0;
      stable_code <= 2'd0;
    end else if (rate_code != cand) begin
      cand   <= rate_code;
      dcount <= 4'd0;
    end else if (dcount != STABLE_MAX) begin
      dcount <= dcount + 4'd1;
      if (dcount == STABLE_LAST && cand != CODE_RSVD) begin
        stable_code <= cand;
      end
    end
  end

  assign code_changed = (stable_code != cur_code);
  assign scnt_inc     = scnt + 4'd1;

  // The sample path is open only while the CIC is not being cleared; both the CIC
  // input gate and the output forwarding key off the registered state alone.
  assign cic_in_strobe = adc_strobe && (state != ST_CLEAR);
  assign forward       = cic_out_strobe && (state == ST_RUN || state == ST_DRAIN);
  assign busy          = (state != ST_RUN);

  // Next-state decision; enter_clear marks every transition that (re)loads the ratio
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next  = state;
    enter_clear = 1'b0;
    case (state)
      ST_RUN: begin
        if (code_changed) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wait for the in-flight output, but never longer than the timeout
        if (cic_out_strobe || timer == DRAIN_LAST) enter_clear = 1'b1;
      end
      ST_CLEAR: begin
        if (code_changed)            enter_clear = 1'b1;
        else if (cnt == CLEAR_LAST)  state_next  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (code_changed) begin
          enter_clear = 1'b1;
        end else if (scnt == SETTLE_N) begin
          // Only reachable with no settling outputs configured
          state_next = ST_RUN;
        end else if (cic_out_strobe && scnt_inc == SETTLE_N) begin
          state_next = ST_RUN;
        end
      end
      default: enter_clear = 1'b1;
    endcase
    if (enter_clear) state_next = ST_CLEAR;
  end

  // State, ratio and the phase counters of the reconfiguration sequence
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_CLEAR;
      cur_code   <= 2'd0;
      decimation <= 6'd20;
      cic_clear  <= 1'b1;
      cnt        <= 8'd0;
      timer      <= 8'd0;
      scnt       <= 4'd0;
    end else begin
      state     <= state_next;
      cic_clear <= (state_next == ST_CLEAR);

      // The ratio only moves on CLEAR entry, while the CIC is held in clear
      if (enter_clear) begin
        cur_code   <= stable_code;
        decimation <= ratio_of(stable_code);
        cnt        <= 8'd0;
      end else if (state == ST_CLEAR) begin
        cnt <= cnt + 8'd1;
      end

      // Drain timer runs only in DRAIN and is zero on entry from RUN
      if (state == ST_DRAIN) timer <= timer + 8'd1;
      else                   timer <= 8'd0;

      // Muted-output count, restarted whenever SETTLE is (re)entered
      if (state != ST_SETTLE) begin
        scnt <= 4'd0;
      end else if (cic_out_strobe && scnt != SETTLE_N) begin
        scnt <= scnt_inc;
      end
    end
  end

  // Output forwarding: one-clock pulse, data held between pulses
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_strobe <= 1'b0;
      out_data   <= '0;
    end else begin
      out_strobe <= forward;
      if (forward) out_data <= cic_out_data;
    end
  end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb_cic_rate_ctrl: self-checking bench for cic_rate_ctrl.
// A phase-level reference model predicts every output on every cycle. Directed
// scenarios with hand-derived literal expectations pin the key timings, and a
// randomized phase exercises arbitrary code, strobe and reset interleavings.
module tb_cic_rate_ctrl;

  localparam int DW             = 18;
  localparam int STABLE_CYCLES  = 4;
  localparam int CLEAR_CYCLES   = 8;
  localparam int SETTLE_OUTPUTS = 5;
  localparam int DRAIN_TIMEOUT  = 255;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    rate_code = 2'd0;
  logic          adc_strobe = 1'b0;
  logic          cic_in_strobe;
  logic [5:0]    decimation;
  logic          cic_clear;
  logic          cic_out_strobe = 1'b0;
  logic [DW-1:0] cic_out_data = '0;
  logic          out_strobe;
  logic [DW-1:0] out_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  cic_rate_ctrl #(
    .DATA_WIDTH(DW), .STABLE_CYCLES(STABLE_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES),
    .SETTLE_OUTPUTS(SETTLE_OUTPUTS), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rate_code(rate_code), .adc_strobe(adc_strobe),
    .cic_in_strobe(cic_in_strobe), .decimation(decimation), .cic_clear(cic_clear),
    .cic_out_strobe(cic_out_strobe), .cic_out_data(cic_out_data),
    .out_strobe(out_strobe), .out_data(out_data), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_RUN, P_DRAIN, P_CLEAR, P_SETTLE} phase_t;

  phase_t        m_phase;
  int            m_code, m_ratio, m_age, m_muted;
  int            m_stable, m_run_code, m_run_len;
  logic          m_ov;
  logic [DW-1:0] m_od;
  logic          m_ok = 1'b0;

  function automatic int ratio_of(input int code);
    int table_r [4] = '{20, 10, 5, 20};
    return table_r[code];
  endfunction

  function automatic void start_clear(input int code);
    m_phase = P_CLEAR;
    m_code  = code;
    m_ratio = ratio_of(code);
    m_age   = 0;
  endfunction

  always @(posedge clock) begin
    int prev_stable;
    if (!reset_n) begin
      m_phase = P_CLEAR; m_code = 0; m_ratio = 20; m_age = 0; m_muted = 0;
      m_ov = 1'b0; m_od = '0;
      m_stable = 0; m_run_code = 0; m_run_len = 1;
      m_ok = 1'b1;
    end else if (m_ok) begin
      prev_stable = m_stable;
      // A code is accepted once seen on STABLE_CYCLES consecutive clocks
      if (int'(rate_code) == m_run_code) begin
        if (m_run_len < STABLE_CYCLES) m_run_len++;
        if (m_run_len == STABLE_CYCLES && m_run_code != 3) m_stable = m_run_code;
      end else begin
        m_run_code = int'(rate_code);
        m_run_len  = 1;
      end
      // Samples pass through only while running or draining
      m_ov = cic_out_strobe && (m_phase == P_RUN || m_phase == P_DRAIN);
      if (m_ov) m_od = cic_out_data;
      case (m_phase)
        P_RUN: if (prev_stable != m_code) begin m_phase = P_DRAIN; m_age = 0; end
        P_DRAIN: begin
          m_age++;
          if (cic_out_strobe || m_age == DRAIN_TIMEOUT) start_clear(prev_stable);
        end
        P_CLEAR: begin
          if (prev_stable != m_code) start_clear(prev_stable);
          else begin
            m_age++;
            if (m_age == CLEAR_CYCLES) begin m_phase = P_SETTLE; m_muted = 0; end
          end
        end
        P_SETTLE: begin
          if (prev_stable != m_code) start_clear(prev_stable);
          else begin
            if (cic_out_strobe) m_muted++;
            if (m_muted >= SETTLE_OUTPUTS) m_phase = P_RUN;
          end
        end
        default: start_clear(prev_stable);
      endcase
    end
  end

  // Compare every output against the model once per cycle, away from the active edge
  always @(negedge clock) begin
    if (m_ok) begin
      check("busy",          32'(busy),          32'(m_phase != P_RUN));
      check("cic_clear",     32'(cic_clear),     32'(m_phase == P_CLEAR));
      check("decimation",    32'(decimation),    32'(m_ratio));
      check("cic_in_strobe", 32'(cic_in_strobe), 32'(adc_strobe && m_phase != P_CLEAR));
      check("out_strobe",    32'(out_strobe),    32'(m_ov));
      check("out_data",      32'(out_data),      32'(m_od));
    end
  end

  // ---------------- stimulus ----------------
  int adc_mode    = 0;  // 0: every 4 clocks, 1: random, 2: stopped
  int strobe_mode = 0;  // 0: CIC-like stub, 1: raw random strobes
  int adc_phase   = 0;
  int stub_cnt    = 0;

  // One clock: sample the CIC-facing outputs, then update all inputs after the edge
  task automatic tick();
    logic       pc, pi;
    logic [5:0] pd;
    @(negedge clock);
    pc = cic_clear; pi = cic_in_strobe; pd = decimation;
    @(posedge clock);
    #1;
    if (strobe_mode == 0) begin
      cic_out_strobe = 1'b0;
      if (pc) stub_cnt = 0;
      else if (pi) begin
        if (stub_cnt >= int'(pd) - 1) begin cic_out_strobe = 1'b1; stub_cnt = 0; end
        else stub_cnt++;
      end
    end else begin
      cic_out_strobe = ($urandom_range(0, 5) == 0);
    end
    cic_out_data = DW'($urandom);
    adc_phase = (adc_phase + 1) % 4;
    case (adc_mode)
      0:       adc_strobe = (adc_phase == 0);
      1:       adc_strobe = 1'($urandom_range(0, 1));
      default: adc_strobe = 1'b0;
    endcase
  endtask

  // Tick until busy (which=0) or cic_clear (which=1) reaches lvl, bounded by limit
  task automatic wait_sig(input int which, input logic lvl, input int limit, input string name,
                          output int n, output int offered, output int fwd);
    n = 0; offered = 0; fwd = 0;
    while (((which == 0) ? busy : cic_clear) !== lvl && n < limit) begin
      if (cic_out_strobe) offered++;
      tick();
      if (out_strobe) fwd++;
      n++;
    end
    check(name, 32'((which == 0) ? busy : cic_clear), 32'(lvl));
  endtask

  // Hold inputs for a number of clocks, recording busy and strobe traffic
  task automatic hold(input int cycles, output logic saw_busy, output int offered, output int fwd);
    saw_busy = 1'b0; offered = 0; fwd = 0;
    for (int i = 0; i < cycles; i++) begin
      if (cic_out_strobe) offered++;
      tick();
      if (out_strobe) fwd++;
      saw_busy = saw_busy | busy;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, off, fw, m;
    logic sb;
    logic [DW-1:0] d;

    // Reset with 48k selected and a strobe every 4 clocks
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_decimation", 32'(decimation), 32'd20);
    check("rst_cic_clear",  32'(cic_clear),  32'd1);
    check("rst_busy",       32'(busy),       32'd1);
    check("rst_out_strobe", 32'(out_strobe), 32'd0);
    check("rst_out_data",   32'(out_data),   32'd0);
    reset_n = 1'b1;
    wait_sig(1, 1'b0, 50, "rst_clear_end", n, off, fw);
    check("rst_clear_len", 32'(n), 32'd8);
    wait_sig(0, 1'b0, 3000, "rst_run", n, off, fw);
    check("rst_muted", 32'(off), 32'd5);
    check("rst_muted_fwd", 32'(fw), 32'd0);
    // The next CIC output is forwarded one clock later and then held
    n = 0;
    while (!cic_out_strobe && n < 500) begin tick(); n++; end
    check("fwd_wait", 32'(cic_out_strobe), 32'd1);
    d = cic_out_data;
    tick();
    check("fwd_strobe", 32'(out_strobe), 32'd1);
    check("fwd_data",   32'(out_data),   32'(d));
    tick();
    check("fwd_pulse_end", 32'(out_strobe), 32'd0);
    check("fwd_data_hold", 32'(out_data),   32'(d));

    // Glitch 0->1->0 with 2 clocks each: nothing happens
    rate_code = 2'd1; tick(); tick();
    rate_code = 2'd0;
    hold(12, sb, off, fw);
    check("glitch_busy", 32'(sb), 32'd0);
    check("glitch_dec",  32'(decimation), 32'd20);

    // Reserved code held: ignored, every output still forwarded
    rate_code = 2'd3;
    hold(100, sb, off, fw);
    rate_code = 2'd0;
    check("rsvd_busy", 32'(sb), 32'd0);
    check("rsvd_fwd",  32'(fw), 32'(off));
    check("rsvd_dec",  32'(decimation), 32'd20);
    hold(8, sb, off, fw);

    // 48k -> 192k from RUN
    rate_code = 2'd2;
    wait_sig(0, 1'b1, 20, "sw_drain", n, off, fw);
    check("sw_drain_delay", 32'(n), 32'd5);
    check("sw_drain_dec",   32'(decimation), 32'd20);
    wait_sig(1, 1'b1, 300, "sw_clear", n, off, fw);
    check("sw_drain_fwd",  32'(fw), 32'd1);
    check("sw_clear_dec",  32'(decimation), 32'd5);
    wait_sig(1, 1'b0, 50, "sw_clear_end", n, off, fw);
    check("sw_clear_len", 32'(n), 32'd8);
    wait_sig(0, 1'b0, 3000, "sw_run", n, off, fw);
    check("sw_muted", 32'(off), 32'd5);
    check("sw_run_dec", 32'(decimation), 32'd5);

    // Back to 48k, then 0->1 and 1->2 after two muted outputs
    rate_code = 2'd0;
    wait_sig(0, 1'b1, 20, "b48_busy", n, off, fw);
    wait_sig(0, 1'b0, 5000, "b48_run", n, off, fw);
    rate_code = 2'd1;
    wait_sig(1, 1'b1, 300, "s96_clear", n, off, fw);
    check("s96_dec", 32'(decimation), 32'd10);
    wait_sig(1, 1'b0, 50, "s96_settle", n, off, fw);
    m = 0; n = 0;
    while (m < 2 && n < 1000) begin
      if (cic_out_strobe) m++;
      tick(); n++;
    end
    check("s96_two_muted", 32'(m), 32'd2);
    check("s96_still_busy", 32'(busy), 32'd1);
    rate_code = 2'd2;
    wait_sig(1, 1'b1, 20, "s192_reclear", n, off, fw);
    check("s192_dec", 32'(decimation), 32'd5);
    wait_sig(1, 1'b0, 50, "s192_clear_end", n, off, fw);
    check("s192_clear_len", 32'(n), 32'd8);
    wait_sig(0, 1'b0, 3000, "s192_run", n, off, fw);
    check("s192_muted", 32'(off), 32'd5);

    // Drain timeout with the sample source stopped
    adc_mode = 2;
    hold(30, sb, off, fw);
    rate_code = 2'd0;
    wait_sig(0, 1'b1, 20, "to_drain", n, off, fw);
    wait_sig(1, 1'b1, 400, "to_clear", n, off, fw);
    check("to_len", 32'(n), 32'd255);
    check("to_dec", 32'(decimation), 32'd20);
    adc_mode = 0;
    wait_sig(0, 1'b0, 5000, "to_run", n, off, fw);

    // Reset in the middle of SETTLE at 192k
    rate_code = 2'd2;
    wait_sig(1, 1'b1, 300, "rs_clear", n, off, fw);
    wait_sig(1, 1'b0, 50, "rs_settle", n, off, fw);
    n = 0;
    while (!cic_out_strobe && n < 500) begin tick(); n++; end
    tick();
    check("rs_in_settle", 32'(busy & ~cic_clear), 32'd1);
    reset_n = 1'b0; rate_code = 2'd0;
    tick();
    check("rs_cic_clear",  32'(cic_clear),  32'd1);
    check("rs_dec",        32'(decimation), 32'd20);
    check("rs_out_strobe", 32'(out_strobe), 32'd0);
    check("rs_busy",       32'(busy),       32'd1);
    reset_n = 1'b1;
    wait_sig(0, 1'b0, 3000, "rs_run", n, off, fw);

    // Randomized traffic: codes, strobes and occasional resets
    adc_mode = 1; strobe_mode = 1;
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      if (n == 0) begin
        rate_code = 2'($urandom_range(0, 3));
        n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 80)) : int'($urandom_range(1, 12));
      end
      n--;
      reset_n = ($urandom_range(0, 799) != 0);
      tick();
    end
    reset_n = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
